// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master with run-time CPOL/CPHA and a start/busy/done handshake.
// Define SPI_LOOPBACK_EN to let the latched loopback bit route spi_mosi back into the receive path.
module spi_master_param #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 2,
  parameter int CS_W    = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [DATA_W-1:0]           tx_data,
  input  logic [CS_W-1:0]             cs_sel,
  input  logic                        cpol,
  input  logic                        cpha,
  input  logic                        loopback,
  input  logic                        spi_miso,
  output logic                        busy,
  output logic                        done,
  output logic [DATA_W-1:0]           rx_data,
  output logic [CS_W-1:0]             spi_cs_l,
  output logic                        spi_clk,
  output logic                        spi_mosi,
  output logic [$clog2(DATA_W+1)-1:0] bit_count
);

  localparam int BCW    = $clog2(DATA_W + 1);
  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam int HALF_W = $clog2(2 * DATA_W);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_TRAIL = DIV_W'(CLK_DIV);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_W - 1);
  localparam logic [BCW-1:0]    BC_FULL   = BCW'(DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL,
    DONE
  } state_t;

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [HALF_W-1:0]   half_cnt;
  logic [DATA_W-1:0]   tx_sh;
  logic [DATA_W-1:0]   rx_sh;
  logic                cpol_q;
  logic                cpha_q;
  logic                lb_q;
  logic                rx_in;
  logic                toggle;
  logic                lead_edge;
  logic                sample;
  logic                drive;

`ifdef SPI_LOOPBACK_EN
  assign rx_in = lb_q ? spi_mosi : spi_miso;
`else
  logic unused_lb;
  assign unused_lb = lb_q;
  assign rx_in     = spi_miso;
`endif

  // Toggle k=0 closes LEAD; toggle k=half_cnt+1 closes each SHIFT half, so even k (odd half_cnt) is a leading edge.
  always_comb begin
    toggle    = 1'b0;
    lead_edge = 1'b0;
    if (div_cnt == DIV_LAST) begin
      if (state == LEAD) begin
        toggle    = 1'b1;
        lead_edge = 1'b1;
      end else if (state == SHIFT && half_cnt != HALF_LAST) begin
        toggle    = 1'b1;
        lead_edge = half_cnt[0];
      end
    end
    sample = toggle && (lead_edge != cpha_q);
    drive  = toggle && (lead_edge == cpha_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      div_cnt   <= '0;
      half_cnt  <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lb_q      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rx_data   <= '0;
      spi_cs_l  <= '1;
      spi_clk   <= 1'b0;
      spi_mosi  <= 1'b0;
      bit_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          spi_mosi <= 1'b0;
          if (start) begin
            state     <= LEAD;
            busy      <= 1'b1;
            div_cnt   <= '0;
            tx_sh     <= tx_data;
            rx_sh     <= '0;
            bit_count <= BC_FULL;
            spi_cs_l  <= ~cs_sel;
            cpol_q    <= cpol;
            cpha_q    <= cpha;
            lb_q      <= loopback;
            spi_clk   <= cpol;
            spi_mosi  <= cpha ? 1'b0 : tx_data[DATA_W-1];
          end else begin
            state <= IDLE;
          end
        end
        LEAD: begin
          if (div_cnt == DIV_LAST) begin
            state    <= SHIFT;
            div_cnt  <= '0;
            half_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (half_cnt == HALF_LAST) begin
              state <= TRAIL;
            end else begin
              half_cnt <= half_cnt + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        TRAIL: begin
          // Holds CS one cycle beyond the idle half-period before releasing it in DONE.
          if (div_cnt == DIV_TRAIL) begin
            state    <= DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
            spi_cs_l <= '1;
            spi_mosi <= 1'b0;
            rx_data  <= rx_sh;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (toggle) begin
        spi_clk <= ~spi_clk;
      end
      if (sample) begin
        rx_sh     <= {rx_sh[DATA_W-2:0], rx_in};
        bit_count <= bit_count - 1'b1;
      end
      // cpha=0 already presented the MSB at accept, so its trailing edges move on to the next bit.
      if (drive) begin
        spi_mosi <= cpha_q ? tx_sh[DATA_W-1] : tx_sh[DATA_W-2];
        tx_sh    <= {tx_sh[DATA_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: doc/spi_master_param.md
# spi_master_param

Parametrised full-duplex SPI master. Generalises the fixed 16-bit, fixed-rate SPI engine to configurable word width, SCLK divider and chip-select count. Adds run-time CPOL/CPHA mode selection and a start/busy/done handshake. Sits between a register/host interface and the SPI pins of one or more slave devices.

## Interface
- DATA_W, 16, word width in bits (>= 2)
- CLK_DIV, 2, SCLK half-period in clk cycles (>= 1)
- CS_W, 1, number of chip-select lines (>= 1)

- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request a transfer; accepted only when busy=0
- tx_data  in  DATA_W  word to transmit, MSB first
- cs_sel  in  CS_W  one-hot/multi-hot mask of slaves to select
- cpol  in  1  SCLK idle level
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
- loopback  in  1  internal MOSI->MISO loopback (see Configuration)
- spi_miso  in  1  serial data from slave
- busy  out  1  high from accept until the done cycle
- done  out  1  one-cycle pulse, rx_data valid
- rx_data  out  DATA_W  last received word, MSB first
- spi_cs_l  out  CS_W  active-low chip selects
- spi_clk  out  1  SCLK
- spi_mosi  out  1  serial data to slave
- bit_count  out  $clog2(DATA_W+1)  bits remaining in current transfer

## Operation
- States: IDLE, LEAD, SHIFT, TRAIL, DONE.
- IDLE: spi_cs_l all 1, spi_clk = latched cpol, spi_mosi = 0. On start=1: latch tx_data, cs_sel, cpol, cpha, loopback; load bit_count=DATA_W; go to LEAD; busy=1.
- start while busy=1 is ignored and has no side effect.
- LEAD, CLK_DIV cycles: spi_cs_l[i]=0 for each cs_sel[i]=1. cpha=0: spi_mosi = bit DATA_W-1 from LEAD entry.
- SHIFT: 2*DATA_W half-periods of CLK_DIV cycles each. spi_clk toggles at the start of every half-period. The first toggle of each bit is the leading edge.
  - cpha=0: sample on the leading edge; shift out the next bit on the trailing edge.
  - cpha=1: drive the bit on the leading edge; sample on the trailing edge.
- Sampling: spi_miso is captured on the same clk edge that toggles spi_clk to the sampling level. Each sample shifts into the receive register LSB-ward and decrements bit_count.
- TRAIL, CLK_DIV cycles: spi_clk at idle level, CS still asserted.
- DONE, 1 cycle: spi_cs_l all 1, rx_data updated, done=1, busy=0, spi_mosi=0. Behaves as IDLE, so a start sampled in this cycle is accepted.
- cs_sel=0: the transfer runs normally with no CS asserted. Multi-hot cs_sel asserts all selected lines.
- Inputs changed mid-transfer have no effect; only values latched at accept are used.

## Timing
- Reset values: busy 0, done 0, rx_data 0, spi_cs_l all 1, spi_clk 0, spi_mosi 0, bit_count 0, latched cpol 0.
- reset_n low mid-transfer: all outputs go to reset values immediately (async). The transfer is discarded; no done pulse.
- Latency: done asserts exactly (2*DATA_W+2)*CLK_DIV+1 cycles after the accepting edge. With defaults this is 69 cycles.
- SCLK period: 2*CLK_DIV clk cycles; exactly DATA_W leading edges per transfer.
- Minimum CS-high gap between back-to-back transfers: 1 clk cycle (the DONE cycle).

## Configuration
- SPI_LOOPBACK_EN defined: when the latched loopback=1, the receive path samples internal spi_mosi instead of spi_miso. Pins still toggle normally.
- SPI_LOOPBACK_EN undefined: the loopback port exists but is ignored; receive always uses spi_miso.

## Test plan
- Mode 0, defaults, tx_data=0xA5C3, slave model returns 0x3C5A:
  - MOSI bit sequence is 0xA5C3 MSB first.
  - 16 rising SCLK edges.
  - rx_data=0x3C5A; done at cycle 69 after accept.
- Mode 3 (cpol=1, cpha=1), tx 0x00FF, slave returns 0xF00F:
  - spi_clk idles 1.
  - MOSI changes only on falling edges.
  - rx_data=0xF00F.
- Handshake:
  - start pulsed during busy is ignored, and the rx_data/tx sequence is unchanged.
  - start held high gives back-to-back transfers with spi_cs_l high for exactly 1 cycle between them.
- reset_n low while bit_count=7:
  - Outputs go immediately to busy 0, spi_cs_l 1, spi_clk 0, rx_data 0.
  - The following transfer of 0x1234 completes correctly.
- CS_W=2, cs_sel=2'b10: only spi_cs_l[1] goes low. cs_sel=0: no CS asserted, done still at 69.
- loopback=1, tx 0x1234, spi_miso tied 0: rx_data=0x1234 with SPI_LOOPBACK_EN defined; rx_data=0x0000 without it.
